// File: rtl/gate_bist_controller_if.sv
// Bundle between the BIST controller and whoever configures and observes it.
// The controller takes the slave side; the gate-model harness takes the master side.
interface gate_bist_controller_if #(
   parameter int IN_W  = 13,
   parameter int OUT_W = 10
);
   logic             start;
   logic             abort;
   logic [OUT_W-1:0] golden;
   logic [OUT_W-1:0] resp_in;
   logic [IN_W-1:0]  pat_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [OUT_W-1:0] signature;

   modport master (
      output start, abort, golden, resp_in,
      input  pat_out, busy, done, pass, signature
   );

   modport slave (
      input  start, abort, golden, resp_in,
      output pat_out, busy, done, pass, signature
   );
endinterface

// File: rtl/gate_bist_controller.sv
// BIST driver for the 13-in / 10-out gate models: LFSR pattern generation,
// one settle cycle per pattern, MISR compaction of the responses and a
// final signature compare against a golden value.
module gate_bist_controller #(
   parameter int          IN_W     = 13,
   parameter int          OUT_W    = 10,
   parameter int          PATTERNS = 256,
   parameter logic [12:0] SEED     = 13'h0001
) (
   input logic                 clk,
   input logic                 rst,
   gate_bist_controller_if.slave bus
);

   localparam int CNT_W = ($clog2(PATTERNS) < 1) ? 1 : $clog2(PATTERNS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);
   // x^3 term of the MISR feedback polynomial x^10+x^3+1
   localparam logic [OUT_W-1:0] MISR_TAP3 = OUT_W'(8);

   typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

   state_t           state;
   logic [IN_W-1:0]  lfsr;
   logic [IN_W-1:0]  lfsr_next;
   logic [OUT_W-1:0] misr;
   logic [OUT_W-1:0] misr_next;
   logic [CNT_W-1:0] count;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [OUT_W-1:0] sig_q;

   // Fibonacci LFSR, x^13+x^4+x^3+x+1, shifting toward the MSB
   assign lfsr_next = {lfsr[IN_W-2:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};

   // MISR step: rotate left, fold the MSB back into bit 3, xor in the response
   assign misr_next = {misr[OUT_W-2:0], misr[OUT_W-1]} ^ bus.resp_in
                      ^ (misr[OUT_W-1] ? MISR_TAP3 : '0);

   // Run sequencer with registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         lfsr   <= IN_W'(SEED);
         misr   <= '0;
         count  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         sig_q  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state  <= APPLY;
                  lfsr   <= IN_W'(SEED);
                  misr   <= '0;
                  count  <= '0;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
               end
            end
            APPLY: begin
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
               end else begin
                  misr <= misr_next;
                  lfsr <= lfsr_next;
                  if (count == LAST) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     sig_q  <= misr_next;
                     pass_q <= (misr_next == bus.golden);
                  end else begin
                     count <= count + 1'b1;
                     state <= APPLY;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               pass_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pat_out   = lfsr;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.signature = sig_q;

endmodule

// File: tb/tb_gate_bist_controller.sv
// Bench for gate_bist_controller: four instances with different run lengths,
// a zero-delay gate model, and a pattern-level reference model of the run.
module tb_gate_bist_controller;

   localparam logic [12:0] SEED = 13'h0001;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [9:0] xmask4;
   logic       stuck_en;

   gate_bist_controller_if #(.IN_W(13), .OUT_W(10)) b1 ();
   gate_bist_controller_if #(.IN_W(13), .OUT_W(10)) b2 ();
   gate_bist_controller_if #(.IN_W(13), .OUT_W(10)) b4 ();
   gate_bist_controller_if #(.IN_W(13), .OUT_W(10)) bb ();

   gate_bist_controller #(.IN_W(13), .OUT_W(10), .PATTERNS(1), .SEED(SEED))
      dut_p1 (.clk(clk), .rst(rst), .bus(b1.slave));
   gate_bist_controller #(.IN_W(13), .OUT_W(10), .PATTERNS(2), .SEED(SEED))
      dut_p2 (.clk(clk), .rst(rst), .bus(b2.slave));
   gate_bist_controller #(.IN_W(13), .OUT_W(10), .PATTERNS(4), .SEED(SEED))
      dut_p4 (.clk(clk), .rst(rst), .bus(b4.slave));
   gate_bist_controller #(.IN_W(13), .OUT_W(10), .PATTERNS(8191), .SEED(SEED))
      dut_big (.clk(clk), .rst(rst), .bus(bb.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [9:0] gate_f(input logic [12:0] p, input logic stuck);
      logic [9:0] g;
      for (int i = 0; i < 10; i++)
         g[i] = p[i] ^ (p[(i + 3) % 13] & p[(i + 7) % 13]) ^ p[12 - i];
      if (stuck) g[2] = 1'b1;
      return g;
   endfunction

   function automatic logic [12:0] lfsr_step(input logic [12:0] l);
      logic fb;
      fb = ^(l & 13'h100D);
      return (l << 1) | {12'd0, fb};
   endfunction

   function automatic logic [9:0] misr_step(input logic [9:0] m, input logic [9:0] r);
      return ((m << 1) & 10'h3FF) ^ (m[9] ? 10'h009 : 10'h000) ^ r;
   endfunction

   // mode 0: constant response c; mode 1: gate model ^ xm with optional stuck-at
   function automatic logic [9:0] ref_sig(input int n, input int mode, input logic [9:0] c,
                                          input logic [9:0] xm, input logic st);
      logic [12:0] l;
      logic [9:0]  m;
      l = SEED;
      m = '0;
      for (int k = 0; k < n; k++) begin
         m = misr_step(m, (mode == 0) ? c : (gate_f(l, st) ^ xm));
         l = lfsr_step(l);
      end
      return m;
   endfunction

   function automatic logic [12:0] ref_pat(input int n);
      logic [12:0] l;
      l = SEED;
      for (int k = 0; k < n; k++) l = lfsr_step(l);
      return l;
   endfunction

   assign b4.resp_in = gate_f(b4.pat_out, 1'b0) ^ xmask4;
   assign bb.resp_in = gate_f(bb.pat_out, stuck_en);

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic busy_of(input int w);
      case (w)
         1:       return b1.busy;
         2:       return b2.busy;
         4:       return b4.busy;
         default: return bb.busy;
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         1:       b1.start = v;
         2:       b2.start = v;
         4:       b4.start = v;
         default: bb.start = v;
      endcase
   endtask

   // leaves the bench at the first negedge after the accepting edge
   task automatic pulse_start(input int w);
      @(negedge clk);
      set_start(w, 1'b1);
      @(negedge clk);
      set_start(w, 1'b0);
   endtask

   task automatic count_busy(input int w, input int bound, output int cyc);
      cyc = 0;
      while (busy_of(w) && cyc < bound) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          cyc;
      int          distinct;
      logic [9:0]  exp_sig;
      logic [9:0]  prev_sig;
      logic [9:0]  good_sig;
      logic [9:0]  c;
      bit          seen [0:8191];

      checks = 0;
      errors = 0;
      rst = 1'b1;
      xmask4 = '0;
      stuck_en = 1'b0;
      b1.start = 0; b1.abort = 0; b1.golden = '0; b1.resp_in = '0;
      b2.start = 0; b2.abort = 0; b2.golden = '0; b2.resp_in = '0;
      b4.start = 0; b4.abort = 0; b4.golden = '0;
      bb.start = 0; bb.abort = 0; bb.golden = '0;

      #7;
      chk("init_pat", 32'(bb.pat_out), 32'h0001);
      chk("init_busy", 32'(bb.busy), 0);
      chk("init_done", 32'(bb.done), 0);
      @(negedge clk);
      rst = 1'b0;

      // PATTERNS=1, constant response 0x155
      b1.resp_in = 10'h155;
      b1.golden  = 10'h155;
      pulse_start(1);
      count_busy(1, 20, cyc);
      chk("p1_busy_cycles", 32'(cyc), 2);
      chk("p1_done", 32'(b1.done), 1);
      chk("p1_sig", 32'(b1.signature), 32'h155);
      chk("p1_pass", 32'(b1.pass), 1);
      chk("p1_pat", 32'(b1.pat_out), 32'h0003);

      // PATTERNS=2, constant response 0x155, golden off by one bit
      b2.resp_in = 10'h155;
      b2.golden  = 10'h3FE;
      pulse_start(2);
      count_busy(2, 20, cyc);
      chk("p2_busy_cycles", 32'(cyc), 4);
      chk("p2_sig", 32'(b2.signature), 32'h3FF);
      chk("p2_pass", 32'(b2.pass), 0);
      chk("p2_done", 32'(b2.done), 1);

      // PATTERNS=2 with random constant responses and golden
      for (int t = 0; t < 4; t++) begin
         c = 10'($urandom);
         exp_sig = ref_sig(2, 0, c, '0, 1'b0);
         b2.resp_in = c;
         b2.golden  = (t % 2 == 0) ? exp_sig : 10'($urandom);
         pulse_start(2);
         count_busy(2, 20, cyc);
         chk("p2r_sig", 32'(b2.signature), 32'(exp_sig));
         chk("p2r_pass", 32'(b2.pass), 32'(b2.golden == exp_sig));
      end

      // PATTERNS=4: start held high every cycle of the run
      xmask4 = 10'($urandom);
      exp_sig = ref_sig(4, 1, '0, xmask4, 1'b0);
      b4.golden = exp_sig;
      @(negedge clk);
      b4.start = 1'b1;
      @(negedge clk);
      count_busy(4, 100, cyc);
      b4.start = 1'b0;
      chk("p4_busy_cycles", 32'(cyc), 8);
      chk("p4_sig", 32'(b4.signature), 32'(exp_sig));
      chk("p4_pass", 32'(b4.pass), 1);
      chk("p4_pat", 32'(b4.pat_out), 32'(ref_pat(4)));
      repeat (3) @(negedge clk);
      chk("p4_no_restart_busy", 32'(b4.busy), 0);
      chk("p4_done_sticky", 32'(b4.done), 1);

      // start in DONE restarts; done drops on the accepting edge
      pulse_start(4);
      chk("p4_restart_done", 32'(b4.done), 0);
      chk("p4_restart_busy", 32'(b4.busy), 1);
      chk("p4_restart_pass", 32'(b4.pass), 0);
      count_busy(4, 100, cyc);
      chk("p4_restart_cycles", 32'(cyc), 8);
      chk("p4_restart_sig", 32'(b4.signature), 32'(exp_sig));
      prev_sig = exp_sig;

      // abort in cycle 3, then an uninterrupted run
      xmask4 = prev_sig ^ 10'($urandom_range(1, 1023));
      exp_sig = ref_sig(4, 1, '0, xmask4, 1'b0);
      b4.golden = exp_sig;
      pulse_start(4);
      @(negedge clk);
      b4.abort = 1'b1;
      @(negedge clk);
      b4.abort = 1'b0;
      chk("abort_busy", 32'(b4.busy), 0);
      chk("abort_done", 32'(b4.done), 0);
      chk("abort_pass", 32'(b4.pass), 0);
      chk("abort_sig_hold", 32'(b4.signature), 32'(prev_sig));
      repeat (2) @(negedge clk);
      chk("abort_stays_idle", 32'(b4.busy), 0);
      pulse_start(4);
      count_busy(4, 100, cyc);
      chk("post_abort_cycles", 32'(cyc), 8);
      chk("post_abort_sig", 32'(b4.signature), 32'(exp_sig));
      chk("post_abort_pass", 32'(b4.pass), 1);

      // asynchronous reset mid-run, between clock edges
      pulse_start(4);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_pat", 32'(b4.pat_out), 32'h0001);
      chk("rst_busy", 32'(b4.busy), 0);
      chk("rst_done", 32'(b4.done), 0);
      chk("rst_pass", 32'(b4.pass), 0);
      chk("rst_sig", 32'(b4.signature), 0);
      chk("rst_sig_p1", 32'(b1.signature), 0);
      chk("rst_done_p1", 32'(b1.done), 0);
      @(negedge clk);
      rst = 1'b0;

      // full-period run against the gate model
      good_sig = ref_sig(8191, 1, '0, '0, 1'b0);
      bb.golden = good_sig;
      for (int run = 0; run < 2; run++) begin
         for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
         pulse_start(9);
         cyc = 0;
         while (bb.busy && cyc < 17000) begin
            seen[bb.pat_out] = 1'b1;
            cyc++;
            @(negedge clk);
         end
         distinct = 0;
         for (int i = 1; i < 8192; i++) if (seen[i]) distinct++;
         chk("big_busy_cycles", 32'(cyc), 16382);
         chk("big_distinct", 32'(distinct), 8191);
         chk("big_zero_unseen", 32'(seen[0]), 0);
         chk("big_sig", 32'(bb.signature), 32'(good_sig));
         chk("big_pass", 32'(bb.pass), 1);
         chk("big_final_pat", 32'(bb.pat_out), 32'(ref_pat(8191)));
      end

      // stuck-at-1 on one gate-model output net
      stuck_en = 1'b1;
      exp_sig = ref_sig(8191, 1, '0, '0, 1'b1);
      pulse_start(9);
      count_busy(9, 17000, cyc);
      chk("stuck_cycles", 32'(cyc), 16382);
      chk("stuck_sig", 32'(bb.signature), 32'(exp_sig));
      chk("stuck_differs", 32'(bb.signature != good_sig), 1);
      chk("stuck_pass", 32'(bb.pass), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
